// File: rtl/branch_resolver.sv
// rtl/branch_resolver.sv - conditional branch/jump resolver with optional taken counter (BRANCH_STATS_EN)
module branch_resolver #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             ex_valid,
    output logic             ex_ready,
    input  logic [1:0]       br_type,
    input  logic             all_zero,
    input  logic [31:0]      pc,
    input  logic [31:0]      imm,
    output logic             target_valid,
    input  logic             target_ready,
    output logic [31:0]      target_pc,
    output logic             taken,
    output logic             flush,
    output logic [CNT_W-1:0] taken_count
);

    localparam logic [1:0] BR_NONE = 2'b00;
    localparam logic [1:0] BR_BEQ  = 2'b01;
    localparam logic [1:0] BR_BNE  = 2'b10;
    localparam logic [1:0] BR_JUMP = 2'b11;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RESOLVE = 2'd1,
        HOLD    = 2'd2
    } state_t;

    state_t      state;
    state_t      next_state;

    logic [1:0]  br_type_q;
    logic        all_zero_q;
    logic [31:0] pc_q;
    logic [29:0] imm_q;

    logic [31:0] pc4;
    logic [31:0] res_pc;
    logic        res_taken;

    // Immediate bits 31:30 fall off the word-offset shift and are never needed.
    logic        unused_imm_hi;
    assign unused_imm_hi = ^imm[31:30];

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic: one resolve cycle, then hold until fetch takes the PC
    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (ex_valid) next_state = RESOLVE;
            RESOLVE: next_state = HOLD;
            HOLD:    if (target_ready) next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // Capture the request; all_zero is frozen here so later flag changes are ignored
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            br_type_q  <= BR_NONE;
            all_zero_q <= 1'b0;
            pc_q       <= '0;
            imm_q      <= '0;
        end else if (state == IDLE && ex_valid) begin
            br_type_q  <= br_type;
            all_zero_q <= all_zero;
            pc_q       <= pc;
            imm_q      <= imm[29:0];
        end
    end

    // Branch decision and target computation from the captured request
    always_comb begin
        pc4       = pc_q + 32'd4;
        res_taken = 1'b0;
        res_pc    = pc4;
        case (br_type_q)
            BR_BEQ:  res_taken = all_zero_q;
            BR_BNE:  res_taken = !all_zero_q;
            BR_JUMP: res_taken = 1'b1;
            default: res_taken = 1'b0;
        endcase
        if (br_type_q == BR_JUMP) begin
            res_pc = {pc4[31:28], imm_q[25:0], 2'b00};
        end else if (res_taken) begin
            res_pc = pc4 + {imm_q, 2'b00};
        end
    end

    // Registered handshake flags follow the next state so outputs never see inputs combinationally
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex_ready     <= 1'b1;
            target_valid <= 1'b0;
        end else begin
            ex_ready     <= (next_state == IDLE);
            target_valid <= (next_state == HOLD);
        end
    end

    // Result registers; flush only fires on the resolve edge so it cannot repeat in HOLD
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            target_pc <= '0;
            taken     <= 1'b0;
            flush     <= 1'b0;
        end else begin
            flush <= 1'b0;
            if (state == RESOLVE) begin
                target_pc <= res_pc;
                taken     <= res_taken;
                flush     <= res_taken;
            end
        end
    end

`ifdef BRANCH_STATS_EN
    logic [CNT_W-1:0] cnt_q;

    // Saturating count of taken results handed to fetch
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else if (target_valid && target_ready && taken && (cnt_q != {CNT_W{1'b1}})) begin
            cnt_q <= cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    end

    assign taken_count = cnt_q;
`else
    assign taken_count = '0;
`endif

endmodule

// File: tb/tb_branch_resolver.sv
// tb/tb_branch_resolver.sv - table-driven scoreboard bench for branch_resolver
module tb_branch_resolver;

    localparam int CW      = 3;
    localparam int CNT_MAX = (1 << CW) - 1;

    logic          clk;
    logic          rst_n;
    logic          ex_valid;
    logic          ex_ready;
    logic [1:0]    br_type;
    logic          all_zero;
    logic [31:0]   pc;
    logic [31:0]   imm;
    logic          target_valid;
    logic          target_ready;
    logic [31:0]   target_pc;
    logic          taken;
    logic          flush;
    logic [CW-1:0] taken_count;

    typedef struct {
        logic [1:0]  bt;
        logic        az;
        logic [31:0] pc;
        logic [31:0] imm;
        logic [31:0] exp_pc;
        logic        exp_taken;
    } vec_t;

    typedef struct {
        logic [31:0] pc;
        logic        taken;
    } exp_t;

    exp_t exp_q[$];
    vec_t tbl[10];
    int   n_checks = 0;
    int   n_fail   = 0;
    int   exp_cnt  = 0;

    branch_resolver #(.CNT_W(CW)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .ex_valid     (ex_valid),
        .ex_ready     (ex_ready),
        .br_type      (br_type),
        .all_zero     (all_zero),
        .pc           (pc),
        .imm          (imm),
        .target_valid (target_valid),
        .target_ready (target_ready),
        .target_pc    (target_pc),
        .taken        (taken),
        .flush        (flush),
        .taken_count  (taken_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    function automatic vec_t model(input logic [1:0] bt, input logic az,
                                   input logic [31:0] p, input logic [31:0] im);
        vec_t v;
        logic [31:0] nxt;
        v.bt = bt; v.az = az; v.pc = p; v.imm = im;
        nxt = p + 32'd4;
        case (bt)
            2'b01:   v.exp_taken = az;
            2'b10:   v.exp_taken = ~az;
            2'b11:   v.exp_taken = 1'b1;
            default: v.exp_taken = 1'b0;
        endcase
        if (bt == 2'b11)      v.exp_pc = {nxt[31:28], im[25:0], 2'b00};
        else if (v.exp_taken) v.exp_pc = nxt + (im << 2);
        else                  v.exp_pc = nxt;
        return v;
    endfunction

    task automatic count_handshake(input logic was_taken);
`ifdef BRANCH_STATS_EN
        if (was_taken && exp_cnt < CNT_MAX) exp_cnt++;
`else
        exp_cnt = was_taken ? 0 : 0;
`endif
    endtask

    task automatic run_req(input vec_t v, input int delay);
        exp_t e;
        int guard;
        logic [31:0] held_pc;
        guard = 0;
        while (!ex_ready && guard < 20) begin
            @(posedge clk); #1; guard++;
        end
        check("ex_ready_idle", 32'(ex_ready), 32'd1);
        br_type = v.bt; all_zero = v.az; pc = v.pc; imm = v.imm;
        ex_valid = 1'b1;
        target_ready = (delay == 0);
        e.pc = v.exp_pc; e.taken = v.exp_taken;
        exp_q.push_back(e);
        @(posedge clk); #1;
        ex_valid = 1'b0;
        all_zero = ~v.az;
        br_type = 2'($urandom); pc = $urandom; imm = $urandom;
        check("ex_ready_resolve", 32'(ex_ready), 32'd0);
        check("valid_resolve", 32'(target_valid), 32'd0);
        guard = 0;
        while (!target_valid && guard < 10) begin
            @(posedge clk); #1; guard++;
        end
        check("valid_latency", 32'(guard), 32'd1);
        if (exp_q.size() == 0) begin
            check("scoreboard_empty", 32'd0, 32'd1);
            return;
        end
        e = exp_q.pop_front();
        check("target_pc", target_pc, e.pc);
        check("taken", 32'(taken), 32'(e.taken));
        check("flush_first", 32'(flush), 32'(e.taken));
        check("ex_ready_hold", 32'(ex_ready), 32'd0);
        held_pc = target_pc;
        for (int k = 0; k < delay; k++) begin
            @(posedge clk); #1;
            check("bp_valid", 32'(target_valid), 32'd1);
            check("bp_pc_stable", target_pc, held_pc);
            check("bp_no_flush", 32'(flush), 32'd0);
            check("bp_ex_ready", 32'(ex_ready), 32'd0);
        end
        target_ready = 1'b1;
        @(posedge clk); #1;
        count_handshake(e.taken);
        check("valid_after_hs", 32'(target_valid), 32'd0);
        check("ex_ready_after_hs", 32'(ex_ready), 32'd1);
        check("flush_after_hs", 32'(flush), 32'd0);
        check("taken_count", 32'(taken_count), 32'(exp_cnt));
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        tbl[0] = '{2'b01, 1'b1, 32'h0000_0100, 32'h0000_0004, 32'h0000_0114, 1'b1};
        tbl[1] = '{2'b10, 1'b1, 32'h0000_0100, 32'h0000_0004, 32'h0000_0104, 1'b0};
        tbl[2] = '{2'b01, 1'b1, 32'h0000_0000, 32'hFFFF_FFFE, 32'hFFFF_FFFC, 1'b1};
        tbl[3] = '{2'b11, 1'b0, 32'hF000_0000, 32'h0000_0010, 32'hF000_0040, 1'b1};
        tbl[4] = '{2'b00, 1'b1, 32'h0000_0200, 32'h0000_0008, 32'h0000_0204, 1'b0};
        tbl[5] = '{2'b01, 1'b0, 32'h0000_1000, 32'h0000_0010, 32'h0000_1004, 1'b0};
        tbl[6] = '{2'b10, 1'b0, 32'h0000_1000, 32'hFFFF_FFFF, 32'h0000_1000, 1'b1};
        tbl[7] = '{2'b11, 1'b1, 32'h7FFF_FFFC, 32'h03FF_FFFF, 32'h8FFF_FFFC, 1'b1};
        tbl[8] = '{2'b11, 1'b0, 32'h0000_0000, 32'hFC00_0001, 32'h0000_0004, 1'b1};
        tbl[9] = '{2'b00, 1'b0, 32'hFFFF_FFFC, 32'h0000_0040, 32'h0000_0000, 1'b0};

        rst_n = 1'b0;
        ex_valid = 1'b1; br_type = 2'($urandom); all_zero = 1'($urandom);
        pc = $urandom; imm = $urandom; target_ready = 1'($urandom);
        repeat (3) @(posedge clk);
        #1;
        check("rst_ex_ready", 32'(ex_ready), 32'd1);
        check("rst_valid", 32'(target_valid), 32'd0);
        check("rst_pc", target_pc, 32'd0);
        check("rst_taken", 32'(taken), 32'd0);
        check("rst_flush", 32'(flush), 32'd0);
        check("rst_count", 32'(taken_count), 32'd0);
        ex_valid = 1'b0; target_ready = 1'b0;
        rst_n = 1'b1;

        for (int i = 0; i < 10; i++) run_req(tbl[i], i % 3);

        // Backpressure: five cycles of target_ready low after a taken beq
        run_req(tbl[0], 5);

        for (int i = 0; i < 16; i++)
            run_req(model(2'($urandom), 1'($urandom), $urandom, $urandom), int'($urandom_range(0, 2)));

        // Reset while the result is held
        while (!ex_ready) begin @(posedge clk); #1; end
        br_type = 2'b01; all_zero = 1'b1; pc = 32'h300; imm = 32'h1;
        ex_valid = 1'b1; target_ready = 1'b0;
        @(posedge clk); #1;
        ex_valid = 1'b0;
        @(posedge clk); #1;
        check("mid_valid", 32'(target_valid), 32'd1);
        check("mid_flush", 32'(flush), 32'd1);
        check("mid_pc", target_pc, 32'h0000_0308);
        rst_n = 1'b0;
        #1;
        exp_cnt = 0;
        exp_q.delete();
        check("mid_rst_valid", 32'(target_valid), 32'd0);
        check("mid_rst_ready", 32'(ex_ready), 32'd1);
        check("mid_rst_pc", target_pc, 32'd0);
        check("mid_rst_taken", 32'(taken), 32'd0);
        check("mid_rst_flush", 32'(flush), 32'd0);
        check("mid_rst_count", 32'(taken_count), 32'd0);
        @(posedge clk); #1;
        check("mid_rst_flush_edge", 32'(flush), 32'd0);
        rst_n = 1'b1;
        run_req('{2'b10, 1'b0, 32'h0000_0400, 32'h0000_0002, 32'h0000_040C, 1'b1}, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
